// File: rtl/apb_prci_rstseq.sv
// -----------------------------------------------------------------------------
// apb_prci_rstseq -- parametrised reset sequencer with APB control/status.
//
// Holds NDOMAIN reset outputs while any of the NLOCK PLL/PHY lock inputs is
// low. Once all locks are stable, it releases the domains in index order,
// one HOLD_CYCLES apart. Losing lock puts every domain back into reset.
// Software can stretch a single domain's reset (bit k>0 of sw_req) or restart
// the whole sequence (bit 0 of sw_req).
//
// Optional feature macro: PRCI_RST_CAUSE_EN
//   When defined, a sticky reset-cause register is added at offset 0x10.
//   This register uses write-1-to-clear.
//   When undefined, offset 0x10 is unmapped.
//
// Ports
//   i_clk       system clock
//   i_pwrreset  asynchronous active-high power-on reset
//   i_mapinfo   base address / mask from the interconnect
//   o_cfg       constant plug-and-play descriptor
//   i_apbi      APB request (psel, penable, pwrite, paddr, pwdata)
//   o_apbo      APB response (prdata, pready, pslverr), all registered
//   i_locked    asynchronous lock inputs, all must be high to run
//   i_lnk_up    asynchronous PCIe link-up, reported in status only
//   o_rst       per-domain reset, active-high
//   o_nrst      per-domain reset, active-low (same flop as o_rst)
//
// Register map (byte offsets of 32-bit words)
//   0x00 RO   [NLOCK-1:0] synced locks, [8] lnk_up, [10:9] FSM state
//   0x04 RO   o_rst
//   0x08 W1S  sw_req (reads the current request mask)
//   0x0C RO   {HOLD_CYCLES[15:0], NLOCK[7:0], NDOMAIN[7:0]}
//   0x10 RW1C cause {SW domain, SW full, lock loss, power-on} (macro only)
// -----------------------------------------------------------------------------
package apb_prci_rstseq_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] mask;
    } mapinfo_type;

    typedef struct packed {
        logic [15:0] vid;
        logic [15:0] did;
        logic [31:0] addr_base;
        logic [31:0] addr_mask;
    } dev_config_type;

    typedef struct packed {
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] paddr;
        logic [31:0] pwdata;
    } apb_in_type;

    typedef struct packed {
        logic [31:0] prdata;
        logic        pready;
        logic        pslverr;
    } apb_out_type;

    localparam logic [15:0] PRCI_VENDOR_ID = 16'h00F1;
    localparam logic [15:0] PRCI_DEVICE_ID = 16'h0A71;
endpackage

module apb_prci_rstseq
    import apb_prci_rstseq_pkg::*;
#(
    parameter int NDOMAIN     = 4,
    parameter int NLOCK       = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_pwrreset,
    input  mapinfo_type          i_mapinfo,
    output dev_config_type       o_cfg,
    input  apb_in_type           i_apbi,
    output apb_out_type          o_apbo,
    input  logic [NLOCK-1:0]     i_locked,
    input  logic                 i_lnk_up,
    output logic [NDOMAIN-1:0]   o_rst,
    output logic [NDOMAIN-1:0]   o_nrst
);

    localparam int CW = $clog2(HOLD_CYCLES);
    localparam int DW = (NDOMAIN > 1) ? $clog2(NDOMAIN) : 1;
    localparam logic [CW-1:0]      CNT_LAST = CW'(HOLD_CYCLES - 1);
    // Domain 0 cannot be stretched on its own; its sw_req bit means "restart all".
    localparam logic [NDOMAIN-1:0] DOM_MASK = ~NDOMAIN'(1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_RELEASE   = 2'd1,
        ST_RUN       = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DW-1:0]       dom_idx_q, dom_idx_d;
    logic [NDOMAIN-1:0]  rst_q, rst_d;
    logic [NDOMAIN-1:0]  sw_req_q, sw_req_d;
    logic [CW-1:0]       dcnt_q [NDOMAIN];
    logic [CW-1:0]       dcnt_d [NDOMAIN];
    logic [NLOCK:0]      sync_q [SYNC_STAGES];

    logic [NLOCK-1:0]    locks_s;
    logic                lnk_s;
    logic                lock_ok_s;
    logic                lock_loss_s;
    logic                setup_s;
    logic                wr_s;
    logic [9:0]          woff_s;
    logic                sw_wr_s;
    logic                sw_full_s;
    logic [NDOMAIN-1:0]  sw_dom_set_s;
    logic [31:0]         rdata_s;
    logic                rerr_s;
    logic [31:0]         prdata_q;
    logic                pready_q;
    logic                pslverr_q;

    // Lock and link-up synchroniser chain; lnk_up rides in the top bit.
    always_ff @(posedge i_clk or posedge i_pwrreset) begin
        if (i_pwrreset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= {i_lnk_up, i_locked};
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign locks_s   = sync_q[SYNC_STAGES-1][NLOCK-1:0];
    assign lnk_s     = sync_q[SYNC_STAGES-1][NLOCK];
    assign lock_ok_s = &locks_s;
    // RELEASE and RUN are only reachable with lock_ok high, so low here is a loss.
    assign lock_loss_s = (state_q != ST_WAIT_LOCK) && !lock_ok_s;

    assign setup_s   = i_apbi.psel & ~i_apbi.penable;
    assign wr_s      = i_apbi.psel & i_apbi.penable & i_apbi.pwrite;
    assign woff_s    = i_apbi.paddr[11:2];
    assign sw_wr_s   = wr_s && (woff_s == 10'd2);
    assign sw_full_s = sw_wr_s & i_apbi.pwdata[0];
    // Requests to domains already held in reset are dropped, so a stretch is never extended.
    assign sw_dom_set_s = sw_wr_s ? (i_apbi.pwdata[NDOMAIN-1:0] & ~rst_q & DOM_MASK)
                                  : {NDOMAIN{1'b0}};

    // Sequencer state registers.
    always_ff @(posedge i_clk or posedge i_pwrreset) begin
        if (i_pwrreset) begin
            state_q   <= ST_WAIT_LOCK;
            cnt_q     <= '0;
            dom_idx_q <= '0;
            rst_q     <= '1;
            sw_req_q  <= '0;
            for (int k = 0; k < NDOMAIN; k++) begin
                dcnt_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dom_idx_q <= dom_idx_d;
            rst_q     <= rst_d;
            sw_req_q  <= sw_req_d;
            for (int k = 0; k < NDOMAIN; k++) begin
                dcnt_q[k] <= dcnt_d[k];
            end
        end
    end

    // Sequencer next state: lock loss beats full SW restart, which beats per-domain requests.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dom_idx_d = dom_idx_q;
        rst_d     = rst_q;
        sw_req_d  = sw_req_q;
        for (int k = 0; k < NDOMAIN; k++) begin
            dcnt_d[k] = dcnt_q[k];
        end

        if (lock_loss_s || sw_full_s) begin
            state_d   = ST_WAIT_LOCK;
            cnt_d     = '0;
            dom_idx_d = '0;
            rst_d     = '1;
            sw_req_d  = '0;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    if (!lock_ok_s) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        // The lock-stable wait doubles as domain 0's stretch.
                        cnt_d    = '0;
                        rst_d[0] = 1'b0;
                        if (NDOMAIN == 1) begin
                            state_d = ST_RUN;
                        end else begin
                            dom_idx_d = DW'(1);
                            state_d   = ST_RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d            = '0;
                        rst_d[dom_idx_q] = 1'b0;
                        if (dom_idx_q == DW'(NDOMAIN - 1)) begin
                            state_d = ST_RUN;
                        end else begin
                            dom_idx_d = dom_idx_q + DW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_RUN: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = ST_WAIT_LOCK;
                    rst_d   = '1;
                end
            endcase

            // Per-domain stretches; a set sw_req bit stays set until its domain is released.
            if (state_q != ST_WAIT_LOCK) begin
                for (int k = 1; k < NDOMAIN; k++) begin
                    if (sw_req_q[k] && !rst_q[k]) begin
                        rst_d[k]  = 1'b1;
                        dcnt_d[k] = '0;
                    end else if (sw_req_q[k]) begin
                        if (dcnt_q[k] == CNT_LAST) begin
                            rst_d[k]    = 1'b0;
                            sw_req_d[k] = 1'b0;
                        end else begin
                            dcnt_d[k] = dcnt_q[k] + CW'(1);
                        end
                    end else begin
                        dcnt_d[k] = dcnt_q[k];
                    end
                end
            end else begin
                sw_req_d = sw_req_q;
            end
            sw_req_d = sw_req_d | sw_dom_set_s;
        end
    end

`ifdef PRCI_RST_CAUSE_EN
    logic [3:0] cause_q, cause_d;
    logic       sw_dom_go_s;

    assign sw_dom_go_s = !lock_loss_s && !sw_full_s && (|sw_dom_set_s);

    // Sticky cause register; a new event wins over a same-cycle W1C of its bit.
    always_comb begin
        cause_d = cause_q;
        if (wr_s && (woff_s == 10'd4)) begin
            cause_d = cause_q & ~i_apbi.pwdata[3:0];
        end else begin
            cause_d = cause_q;
        end
        if (lock_loss_s) begin
            cause_d[1] = 1'b1;
        end else if (sw_full_s) begin
            cause_d[2] = 1'b1;
        end else if (sw_dom_go_s) begin
            cause_d[3] = 1'b1;
        end else begin
            cause_d[0] = cause_d[0];
        end
    end

    // Cause register; power-on leaves only the power-on bit set.
    always_ff @(posedge i_clk or posedge i_pwrreset) begin
        if (i_pwrreset) begin
            cause_q <= 4'b0001;
        end else begin
            cause_q <= cause_d;
        end
    end
`else
    logic cause_unused_s;
    assign cause_unused_s = 1'b0;
`endif

    // APB read mux, evaluated on the setup phase.
    always_comb begin
        rdata_s = 32'd0;
        rerr_s  = 1'b0;
        case (woff_s)
            10'd0: begin
                rdata_s[NLOCK-1:0] = locks_s;
                rdata_s[8]         = lnk_s;
                rdata_s[10:9]      = state_q;
            end
            10'd1: rdata_s[NDOMAIN-1:0] = rst_q;
            10'd2: rdata_s[NDOMAIN-1:0] = sw_req_q;
            10'd3: rdata_s = {16'(HOLD_CYCLES), 8'(NLOCK), 8'(NDOMAIN)};
`ifdef PRCI_RST_CAUSE_EN
            10'd4: rdata_s[3:0] = cause_q;
`endif
            default: rerr_s = 1'b1;
        endcase
    end

    // APB response registers: captured in setup, presented during access.
    always_ff @(posedge i_clk or posedge i_pwrreset) begin
        if (i_pwrreset) begin
            prdata_q  <= 32'd0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            pready_q  <= setup_s;
            prdata_q  <= (setup_s && !i_apbi.pwrite) ? rdata_s : 32'd0;
            pslverr_q <= setup_s ? rerr_s : 1'b0;
        end
    end

    assign o_apbo.prdata  = prdata_q;
    assign o_apbo.pready  = pready_q;
    assign o_apbo.pslverr = pslverr_q;

    assign o_rst  = rst_q;
    assign o_nrst = ~rst_q;

    assign o_cfg.vid       = PRCI_VENDOR_ID;
    assign o_cfg.did       = PRCI_DEVICE_ID;
    assign o_cfg.addr_base = i_mapinfo.addr & i_mapinfo.mask;
    assign o_cfg.addr_mask = i_mapinfo.mask;

    logic apb_unused_s;
    assign apb_unused_s = ^{i_apbi.paddr[31:12], i_apbi.paddr[1:0], i_apbi.pwdata};

endmodule

// File: tb/tb_apb_prci_rstseq.sv
// -----------------------------------------------------------------------------
// Directed testbench for apb_prci_rstseq with default parameters
// (NDOMAIN=4, NLOCK=2, HOLD_CYCLES=16, SYNC_STAGES=2).
// Inputs change on the falling edge, and outputs are sampled there too.
// Build with PRCI_RST_CAUSE_EN defined to also cover the cause register.
// -----------------------------------------------------------------------------
module tb_apb_prci_rstseq;
    import apb_prci_rstseq_pkg::*;

    logic           clk = 1'b0;
    logic           pwrreset;
    mapinfo_type    mapinfo;
    dev_config_type cfg;
    apb_in_type     apbi;
    apb_out_type    apbo;
    logic [1:0]     locked;
    logic           lnk_up;
    logic [3:0]     rst;
    logic [3:0]     nrst;

    int checks = 0;
    int errors = 0;

    apb_prci_rstseq dut (
        .i_clk      (clk),
        .i_pwrreset (pwrreset),
        .i_mapinfo  (mapinfo),
        .o_cfg      (cfg),
        .i_apbi     (apbi),
        .o_apbo     (apbo),
        .i_locked   (locked),
        .i_lnk_up   (lnk_up),
        .o_rst      (rst),
        .o_nrst     (nrst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        apbi.psel = 1'b1; apbi.penable = 1'b0; apbi.pwrite = 1'b1;
        apbi.paddr = a; apbi.pwdata = d;
        @(negedge clk);
        apbi.penable = 1'b1;
        @(negedge clk);
        apbi.psel = 1'b0; apbi.penable = 1'b0; apbi.pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d,
                            output logic e, output logic r);
        apbi.psel = 1'b1; apbi.penable = 1'b0; apbi.pwrite = 1'b0; apbi.paddr = a;
        @(negedge clk);
        apbi.penable = 1'b1;
        d = apbo.prdata; e = apbo.pslverr; r = apbo.pready;
        @(negedge clk);
        apbi.psel = 1'b0; apbi.penable = 1'b0;
    endtask

    // Counts falling edges until o_rst differs from its value at entry (bounded).
    task automatic wait_change(output int n, output logic [3:0] v);
        logic [3:0] old;
        old = rst;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rst === old && n < 100);
        v = rst;
    endtask

    task automatic seq_from(input string tag, input logic [3:0] first, input int first_n);
        int n;
        logic [3:0] v;
        wait_change(n, v); chk({tag, "_d0_cyc"}, n, first_n); chk({tag, "_d0_val"}, v, first);
        wait_change(n, v); chk({tag, "_d1_cyc"}, n, 16);      chk({tag, "_d1_val"}, v, 4'b1100);
        wait_change(n, v); chk({tag, "_d2_cyc"}, n, 16);      chk({tag, "_d2_val"}, v, 4'b1000);
        wait_change(n, v); chk({tag, "_d3_cyc"}, n, 16);      chk({tag, "_d3_val"}, v, 4'b0000);
    endtask

    initial begin
        int n;
        logic [3:0] v;
        logic [31:0] d;
        logic e, r;

        pwrreset = 1'b1;
        locked   = 2'b11;
        lnk_up   = 1'b1;
        mapinfo  = '{addr: 32'h8000_1234, mask: 32'hFFFF_F000};
        apbi     = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_orst", rst, 4'hF);
        chk("rst_onrst", nrst, 4'h0);
        chk("rst_prdata", apbo.prdata, 32'd0);
        chk("rst_pready", apbo.pready, 1'b0);
        chk("rst_pslverr", apbo.pslverr, 1'b0);
        chk("cfg_base", cfg.addr_base, 32'h8000_1000);
        chk("cfg_vid", cfg.vid, 16'h00F1);

        // Test 1: power-on sequence, 2 sync cycles plus 16 per domain
        pwrreset = 1'b0;
        seq_from("t1", 4'b1110, 18);
        chk("t1_nrst", nrst, 4'hF);
        apb_read(32'h00, d, e, r);
        chk("t1_status", d, 32'h0000_0503);
        chk("t1_pready", r, 1'b1);
        chk("t1_status_err", e, 1'b0);

        // Test 5: ID register, unmapped offsets
        apb_read(32'h0C, d, e, r);
        chk("t5_id", d, 32'h0010_0204);
        apb_read(32'h14, d, e, r);
        chk("t5_0x14_data", d, 32'd0);
        chk("t5_0x14_err", e, 1'b1);
        apb_read(32'h10, d, e, r);
`ifdef PRCI_RST_CAUSE_EN
        chk("cause_por", d, 32'h1);
        chk("cause_por_err", e, 1'b0);
`else
        chk("t5_0x10_data", d, 32'd0);
        chk("t5_0x10_err", e, 1'b1);
`endif
        apb_read(32'h04, d, e, r);
        chk("t1_orst_reg", d, 32'd0);

        // Test 3: single-domain stretch, repeat request ignored
        apb_write(32'h08, 32'h4);
        chk("t3_not_yet", rst, 4'b0000);
        apb_read(32'h08, d, e, r);
        chk("t3_swreq_set", d, 32'h4);
        chk("t3_orst_held", rst, 4'b0100);
        apb_write(32'h08, 32'h4);
        wait_change(n, v);
        chk("t3_hold_cyc", n, 13);
        chk("t3_release", v, 4'b0000);
        apb_read(32'h08, d, e, r);
        chk("t3_swreq_clr", d, 32'h0);
        // Two domains stretched in parallel
        apb_write(32'h08, 32'hA);
        wait_change(n, v);
        chk("t3p_assert_cyc", n, 1);
        chk("t3p_assert_val", v, 4'b1010);
        wait_change(n, v);
        chk("t3p_hold_cyc", n, 16);
        chk("t3p_release", v, 4'b0000);
`ifdef PRCI_RST_CAUSE_EN
        apb_read(32'h10, d, e, r);
        chk("cause_swdom", d, 32'h9);
        apb_write(32'h10, 32'h9);
        apb_read(32'h10, d, e, r);
        chk("cause_w1c", d, 32'h0);
`endif

        // Test 2: one-cycle lock drop while a domain stretch is pending
        apb_write(32'h08, 32'h2);
        locked = 2'b01;
        @(negedge clk);
        locked = 2'b11;
        wait_change(n, v);
        chk("t2_loss_cyc", n, 2);
        chk("t2_loss_val", v, 4'hF);
        seq_from("t2", 4'b1110, 16);
        apb_read(32'h08, d, e, r);
        chk("t2_swreq_clr", d, 32'h0);
`ifdef PRCI_RST_CAUSE_EN
        apb_read(32'h10, d, e, r);
        chk("cause_lock", d, 32'hA);
        apb_write(32'h10, 32'h2);
        apb_read(32'h10, d, e, r);
        chk("cause_w1c_lock", d, 32'h8);
`endif

        // Test 4: SW full restart, then power-on reset mid-sequence
        apb_write(32'h08, 32'h1);
        chk("t4_all_rst", rst, 4'hF);
        wait_change(n, v);
        chk("t4_d0_cyc", n, 16);
        chk("t4_d0_val", v, 4'b1110);
        apb_read(32'h00, d, e, r);
        chk("t4_status_rel", d, 32'h0000_0303);
`ifdef PRCI_RST_CAUSE_EN
        apb_read(32'h10, d, e, r);
        chk("cause_swfull", d, 32'hC);
`endif
        pwrreset = 1'b1;
        #1;
        chk("por_async_rst", rst, 4'hF);
        chk("por_async_nrst", nrst, 4'h0);
        @(negedge clk);
        pwrreset = 1'b0;
        seq_from("por", 4'b1110, 18);
`ifdef PRCI_RST_CAUSE_EN
        apb_read(32'h10, d, e, r);
        chk("cause_por_again", d, 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
